// File: rtl/scmp_opfetch.sv
// SC/MP instruction fetch: pre-increments P0 within its 4K page, reads opcode and optional displacement.
// Optional bus watchdog enabled by defining SCMP_OPFETCH_TIMEOUT_EN.
module scmp_opfetch #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_load,
    input  logic          fetch_req,
    output logic [AW-1:0] bus_addr,
    output logic          bus_rd,
    input  logic          bus_ack,
    input  logic [7:0]    bus_din,
    output logic [7:0]    op,
    output logic [7:0]    disp,
    output logic          two_byte,
    output logic          op_valid,
    input  logic          op_taken,
    output logic [AW-1:0] pc_out,
    output logic          bus_err
);

    typedef enum logic [1:0] {IDLE, RD_OP, RD_DISP, HOLD} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_inc;
    logic          timeout;

    // Offset wraps inside the page; the page field is never carried into.
    assign pc_inc   = {pc[AW-1:12], pc[11:0] + 12'd1};
    assign pc_out   = pc;
    assign two_byte = op[7];

`ifdef SCMP_OPFETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign timeout = bus_rd && !bus_ack && !pc_load && (wait_cnt == CW'(TIMEOUT - 1));

    // Counts consecutive unacknowledged read cycles; any ack or idle bus restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            if (pc_load || !bus_rd || bus_ack) begin
                wait_cnt <= '0;
            end else if (timeout) begin
                wait_cnt <= '0;
                bus_err  <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            bus_addr <= '0;
            bus_rd   <= 1'b0;
            op       <= 8'h00;
            disp     <= 8'h00;
            op_valid <= 1'b0;
        end else if (pc_load) begin
            // A load discards any in-flight read and any coincident request.
            pc       <= pc_in;
            bus_rd   <= 1'b0;
            op_valid <= 1'b0;
            state    <= IDLE;
        end else if (timeout) begin
            bus_rd <= 1'b0;
            state  <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        pc       <= pc_inc;
                        bus_addr <= pc_inc;
                        bus_rd   <= 1'b1;
                        state    <= RD_OP;
                    end
                end
                RD_OP: begin
                    if (bus_ack) begin
                        op <= bus_din;
                        if (bus_din[7]) begin
                            pc       <= pc_inc;
                            bus_addr <= pc_inc;
                            state    <= RD_DISP;
                        end else begin
                            disp     <= 8'h00;
                            bus_rd   <= 1'b0;
                            op_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                RD_DISP: begin
                    if (bus_ack) begin
                        disp     <= bus_din;
                        bus_rd   <= 1'b0;
                        op_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // Back-to-back fetch when the consumer takes and requests together.
                    if (op_taken) begin
                        op_valid <= 1'b0;
                        if (fetch_req) begin
                            pc       <= pc_inc;
                            bus_addr <= pc_inc;
                            bus_rd   <= 1'b1;
                            state    <= RD_OP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_opfetch.sv
// Directed bench for scmp_opfetch: scoreboard of expected op/disp/pc, cycle-accurate handshake checks.
module tb_scmp_opfetch;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          pc_load = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] bus_addr;
    logic          bus_rd;
    logic          bus_ack = 1'b0;
    logic [7:0]    bus_din = 8'h00;
    logic [7:0]    op;
    logic [7:0]    disp;
    logic          two_byte;
    logic          op_valid;
    logic          op_taken = 1'b0;
    logic [AW-1:0] pc_out;
    logic          bus_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [7:0]  op;
        logic [7:0]  disp;
        logic        two;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    scmp_opfetch #(.AW(AW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_in     (pc_in),
        .pc_load   (pc_load),
        .fetch_req (fetch_req),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_ack   (bus_ack),
        .bus_din   (bus_din),
        .op        (op),
        .disp      (disp),
        .two_byte  (two_byte),
        .op_valid  (op_valid),
        .op_taken  (op_taken),
        .pc_out    (pc_out),
        .bus_err   (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic take();
        op_taken = 1'b1;
        tick();
        op_taken = 1'b0;
        chk("take.op_valid", op_valid, 0);
        chk("take.bus_rd", bus_rd, 0);
    endtask

    // Issues one fetch, answers the bus with the given wait states, checks latency and scoreboard.
    task automatic do_fetch(input string tag, input logic [7:0] ob, input logic [7:0] db,
                            input int waits, input logic chained,
                            input logic [15:0] a1, input logic [15:0] a2, input int exp_lat);
        exp_t e;
        int   lat;
        e.op   = ob;
        e.disp = ob[7] ? db : 8'h00;
        e.two  = ob[7];
        e.pc   = ob[7] ? a2 : a1;
        sb.push_back(e);

        fetch_req = 1'b1;
        op_taken  = chained;
        tick();
        fetch_req = 1'b0;
        op_taken  = 1'b0;
        lat = 1;
        chk({tag, ".rd_rise"}, bus_rd, 1);
        chk({tag, ".addr1"}, bus_addr, a1);
        repeat (waits) begin
            tick();
            lat++;
            chk({tag, ".addr1_hold"}, bus_addr, a1);
            chk({tag, ".rd1_hold"}, bus_rd, 1);
        end
        bus_ack = 1'b1;
        bus_din = ob;
        tick();
        lat++;
        bus_ack = 1'b0;
        bus_din = 8'h00;
        if (ob[7]) begin
            chk({tag, ".rd2"}, bus_rd, 1);
            chk({tag, ".addr2"}, bus_addr, a2);
            repeat (waits) begin
                tick();
                lat++;
                chk({tag, ".addr2_hold"}, bus_addr, a2);
                chk({tag, ".op_valid_wait"}, op_valid, 0);
            end
            bus_ack = 1'b1;
            bus_din = db;
            tick();
            lat++;
            bus_ack = 1'b0;
            bus_din = 8'h00;
        end
        chk({tag, ".op_valid"}, op_valid, 1);
        chk({tag, ".rd_drop"}, bus_rd, 0);
        chk({tag, ".latency"}, lat, exp_lat);
        e = sb.pop_front();
        chk({tag, ".op"}, op, e.op);
        chk({tag, ".disp"}, disp, e.disp);
        chk({tag, ".two_byte"}, two_byte, e.two);
        chk({tag, ".pc_out"}, pc_out, e.pc);
        $display("fetch %s: op=%02h disp=%02h pc=%04h latency=%0d", tag, op, disp, pc_out, lat);
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst.pc", pc_out, 16'h0000);
        chk("rst.bus_rd", bus_rd, 0);
        chk("rst.bus_addr", bus_addr, 16'h0000);
        chk("rst.op", op, 8'h00);
        chk("rst.disp", disp, 8'h00);
        chk("rst.op_valid", op_valid, 0);
        chk("rst.bus_err", bus_err, 0);
        rst_n = 1'b1;
        tick();

        // 1-byte op, zero wait
        do_fetch("t1", 8'h08, 8'h00, 0, 1'b0, 16'h0001, 16'h0002, 2);
        take();

        // Page-local wrap of the offset
        pc_load = 1'b1;
        pc_in   = 16'h1FFF;
        tick();
        pc_load = 1'b0;
        chk("t2.load", pc_out, 16'h1FFF);
        do_fetch("t2", 8'hC4, 8'h55, 0, 1'b0, 16'h1000, 16'h1001, 3);
        take();

        // 2-byte op, 3 wait states per byte; left in HOLD for the chained fetch
        do_fetch("t3", 8'h90, 8'h12, 3, 1'b0, 16'h1002, 16'h1003, 9);

        // Take + request together: no bubble
        do_fetch("t4", 8'h01, 8'h00, 0, 1'b1, 16'h1004, 16'h1005, 2);
        fetch_req = 1'b1;
        repeat (3) begin
            tick();
            chk("t4.req_no_take.bus_rd", bus_rd, 0);
            chk("t4.req_no_take.op_valid", op_valid, 1);
        end
        fetch_req = 1'b0;
        take();
        $display("t4 request without take ignored");

        // pc_load during RD_DISP with a coincident ack and request
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t5.addr1", bus_addr, 16'h1005);
        bus_ack = 1'b1;
        bus_din = 8'h80;
        tick();
        chk("t5.addr2", bus_addr, 16'h1006);
        chk("t5.rd_disp", bus_rd, 1);
        pc_load   = 1'b1;
        pc_in     = 16'h2000;
        fetch_req = 1'b1;
        bus_din   = 8'h33;
        tick();
        pc_load   = 1'b0;
        fetch_req = 1'b0;
        bus_ack   = 1'b0;
        chk("t5.bus_rd", bus_rd, 0);
        chk("t5.op_valid", op_valid, 0);
        chk("t5.pc", pc_out, 16'h2000);
        tick();
        chk("t5.req_dropped", bus_rd, 0);
        chk("t5.op_valid2", op_valid, 0);
        $display("t5 pc_load aborted displacement read, pc=%04h", pc_out);
        do_fetch("t5b", 8'h0C, 8'h00, 0, 1'b0, 16'h2001, 16'h2002, 2);
        take();

        // Ack with no read outstanding is ignored
        bus_ack = 1'b1;
        bus_din = 8'hFF;
        tick();
        bus_ack = 1'b0;
        chk("stray_ack.op", op, 8'h0C);
        chk("stray_ack.op_valid", op_valid, 0);
        chk("stray_ack.bus_rd", bus_rd, 0);
        $display("stray ack ignored, op=%02h", op);

        // Missing ack
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t6.rd_rise", bus_rd, 1);
        chk("t6.addr", bus_addr, 16'h2002);
`ifdef SCMP_OPFETCH_TIMEOUT_EN
        repeat (3) begin
            tick();
            chk("t6.wait.bus_err", bus_err, 0);
            chk("t6.wait.bus_rd", bus_rd, 1);
        end
        tick();
        chk("t6.bus_err", bus_err, 1);
        chk("t6.bus_rd", bus_rd, 0);
        chk("t6.op_valid", op_valid, 0);
        chk("t6.pc", pc_out, 16'h2002);
        tick();
        chk("t6.bus_err_pulse", bus_err, 0);
        chk("t6.idle", bus_rd, 0);
        $display("t6 watchdog abort, pc=%04h", pc_out);
`else
        begin
            int held = 0;
            repeat (1000) begin
                tick();
                if (bus_rd === 1'b1 && bus_err === 1'b0) held++;
            end
            chk("t6.held_cycles", held, 1000);
        end
        pc_load = 1'b1;
        pc_in   = 16'h0100;
        tick();
        pc_load = 1'b0;
        chk("t6.recover.bus_rd", bus_rd, 0);
        chk("t6.recover.pc", pc_out, 16'h0100);
        $display("t6 read held 1000 cycles without ack");
`endif

        // Asynchronous reset in the middle of RD_OP
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("ar.rd_before", bus_rd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.bus_rd", bus_rd, 0);
        chk("ar.bus_addr", bus_addr, 16'h0000);
        chk("ar.pc", pc_out, 16'h0000);
        chk("ar.op", op, 8'h00);
        chk("ar.disp", disp, 8'h00);
        chk("ar.two_byte", two_byte, 0);
        chk("ar.op_valid", op_valid, 0);
        chk("ar.bus_err", bus_err, 0);
        $display("async reset mid RD_OP: outputs cleared");
        tick();
        rst_n = 1'b1;
        tick();
        do_fetch("post_rst", 8'h3F, 8'h00, 1, 1'b0, 16'h0001, 16'h0002, 3);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
